// File: rtl/izq_der_ctrl.sv
// Bit-serial MSB-first magnitude comparison sequencer.
// Latches two words on start, scans one bit per clock and reports w (A>B) / z (A<=B) with a done pulse.
module izq_der_ctrl #(
    parameter int WIDTH      = 8,
    parameter bit EARLY_EXIT = 1'b1,
    localparam int CW        = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] wordA,
    input  logic [WIDTH-1:0] wordB,
    output logic             busy,
    output logic             done,
    output logic             w,
    output logic             z,
    output logic [CW-1:0]    bits_scanned
);

    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_DONE
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_a, r_b, w_a_nxt, w_b_nxt;
    logic [IW-1:0]    r_idx, w_idx_nxt;
    logic [CW-1:0]    r_cnt, w_cnt_nxt;
    logic             r_decided, w_decided_nxt;
    logic             r_busy, w_busy_nxt;
    logic             r_done, w_done_nxt;
    logic             r_w, w_w_nxt;
    logic             r_z, w_z_nxt;

    logic             w_bit_a;
    logic             w_diff;
    logic             w_last;

    assign w_bit_a = r_a[r_idx];
    assign w_diff  = r_a[r_idx] ^ r_b[r_idx];
    assign w_last  = (r_idx == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_a       <= '0;
            r_b       <= '0;
            r_idx     <= IW'(WIDTH - 1);
            r_cnt     <= '0;
            r_decided <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_w       <= 1'b0;
            r_z       <= 1'b1;
        end else begin
            r_state   <= w_state_nxt;
            r_a       <= w_a_nxt;
            r_b       <= w_b_nxt;
            r_idx     <= w_idx_nxt;
            r_cnt     <= w_cnt_nxt;
            r_decided <= w_decided_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
            r_w       <= w_w_nxt;
            r_z       <= w_z_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_a_nxt       = r_a;
        w_b_nxt       = r_b;
        w_idx_nxt     = r_idx;
        w_cnt_nxt     = r_cnt;
        w_decided_nxt = r_decided;
        w_busy_nxt    = r_busy;
        w_done_nxt    = 1'b0;
        w_w_nxt       = r_w;
        w_z_nxt       = r_z;

        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_a_nxt       = wordA;
                    w_b_nxt       = wordB;
                    w_idx_nxt     = IW'(WIDTH - 1);
                    w_cnt_nxt     = '0;
                    w_decided_nxt = 1'b0;
                    w_busy_nxt    = 1'b1;
                    w_state_nxt   = S_SCAN;
                end
            end
            S_SCAN: begin
                w_cnt_nxt = r_cnt + CW'(1);
                // First difference decides; later differences (EARLY_EXIT=0) leave the result frozen.
                if (w_diff && !r_decided) begin
                    w_w_nxt       = w_bit_a;
                    w_z_nxt       = ~w_bit_a;
                    w_decided_nxt = 1'b1;
                end else if (w_last && !r_decided) begin
                    w_w_nxt = 1'b0;
                    w_z_nxt = 1'b1;
                end
                if ((EARLY_EXIT && w_diff) || w_last) begin
                    w_busy_nxt  = 1'b0;
                    w_done_nxt  = 1'b1;
                    w_state_nxt = S_DONE;
                end else begin
                    w_idx_nxt = r_idx - IW'(1);
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    assign busy         = r_busy;
    assign done         = r_done;
    assign w            = r_w;
    assign z            = r_z;
    assign bits_scanned = r_cnt;

endmodule

// File: doc/izq_der_ctrl.md
Name: izq_der_ctrl

Overview:
- Sequential, bit-serial MSB-first ("left to right") magnitude-comparison controller for the Comparador datapath family.
- Accepts two WIDTH-bit words on a start pulse and latches them.
- Scans one bit per clock from MSB to LSB and stops at the first differing bit.
- Reports w (A>B) and z (A<=B) with a one-cycle done pulse. Intended as the sequencer in front of shared compare resources where combinational depth is unacceptable.

Parameters:
WIDTH, 8, operand width in bits; must be >= 2
EARLY_EXIT, 1, 1 = stop at first differing bit; 0 = always scan all WIDTH bits (constant latency), result frozen at first difference
CW, $clog2(WIDTH+1), width of bits_scanned (derived localparam, not overridable)

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
start  input  1  request; sampled only in IDLE
wordA  input  WIDTH  operand A; latched on accepted start
wordB  input  WIDTH  operand B; latched on accepted start
busy  output  1  high while in SCAN
done  output  1  one-cycle pulse: w/z/bits_scanned valid
w  output  1  1 when A>B
z  output  1  1 when A<=B; always ~w after reset/done
bits_scanned  output  CW  bits examined in the last/current operation

Behaviour:
- One clock domain. Reset is synchronous and active-high: clk and reset as named above.
- Reset values: state=IDLE, busy=0, done=0, w=0, z=1, bits_scanned=0, internal idx=WIDTH-1, decided flag=0.
- Reset mid-SCAN aborts the operation. No done pulse is produced. Outputs go to reset values on that edge.
- FSM states: IDLE, SCAN, DONE. All outputs are registered.
- IDLE:
  - On an edge with start=1: latch wordA/wordB, set idx=WIDTH-1, bits_scanned=0, decided=0, busy=1, go to SCAN.
  - w/z keep their previous result.
- SCAN: each edge examines A[idx] vs B[idx] and increments bits_scanned.
  - Bits differ and not yet decided: w<=A[idx], z<=~A[idx], decided<=1.
  - If EARLY_EXIT=1 and the bits differ, go to DONE.
  - If idx==0: if not yet decided, set w<=0, z<=1 (equal). Go to DONE.
  - Otherwise idx<=idx-1.
- Transition into DONE drives busy<=0 and done<=1.
- DONE: lasts exactly one cycle, done high. Next edge: done<=0, go to IDLE. w, z and bits_scanned hold until the next accepted start.
- Latency: with the start edge as edge 0, done is high in the cycle after edge n.
  - n = number of bits scanned = WIDTH - i, where i is the index of the first differing bit. n = WIDTH if the words are equal or EARLY_EXIT=0.
  - Minimum n=1 (MSB differs); maximum n=WIDTH.
- start while in SCAN or DONE is ignored (no queuing). Back-to-back requests are possible from the first IDLE cycle after DONE.
- wordA/wordB changes after acceptance have no effect.
- Equal operands always yield w=0, z=1.
- Invariant: z==~w at all times.

Test Plan:
- Reset, then A=8'h00, B=8'h00, start -> done after 8 scan edges, w=0, z=1, bits_scanned=8.
- A=8'b11100111, B=8'b10000001 -> first difference at bit 6; done after 2 scan edges, w=1, z=0, bits_scanned=2.
- A=8'h0A, B=8'h09 -> difference at bit 1, bits_scanned=7, w=1, z=0. A=8'h00, B=8'h01 -> bits_scanned=8, w=0, z=1.
- start re-pulsed and wordA/wordB changed mid-SCAN (A=8'h06, B=8'h01 accepted) -> ignored; single done, w=1, z=0, result reflects latched operands; start one cycle after done is accepted.
- reset asserted on 3rd SCAN edge -> no done pulse, busy=0, w=0, z=1, bits_scanned=0 next cycle; a new start completes normally.
- EARLY_EXIT=0, A=8'h80, B=8'h7F -> w=1, z=0, bits_scanned=8, done 8 scan edges after start (result not overwritten by later differing bits).
